led_fader: RTL and testbench

- Downstream stage of the LED blinker. Consumes the blinker's square-wave LED level and drives the physical LED through PWM.
- Each on/off transition becomes a linear brightness ramp (a "breathing" effect) instead of a hard edge.
- Comprises a free-running PWM counter, a ramp step prescaler and a 4-state ramp FSM. An enable input bypasses fading.

---
 rtl/led_fader.sv | 73 +++++++
 tb/tb_led_fader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: PWM LED driver that turns each led_in transition into a linear brightness ramp.
module led_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 49_019
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_in,
    input  logic                enable,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_t;
    state_t state, state_n;
    logic [PWM_BITS-1:0] duty_n, pwm_cnt, cmp_duty;
    logic [SW-1:0] step_cnt, step_n;
    logic tick;
    assign tick = step_cnt == STEP_LAST;
    assign busy = state == UP || state == DOWN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            duty     <= '0;
            step_cnt <= '0;
            pwm_cnt  <= '0;
            cmp_duty <= '0;
            led_out  <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            step_cnt <= step_n;
            pwm_cnt  <= pwm_cnt + 1'b1;
            // shadow load at the period end keeps the running period glitch-free
            if (pwm_cnt == MAX) cmp_duty <= duty;
            led_out  <= enable ? (pwm_cnt < cmp_duty || cmp_duty == MAX) : led_in;
        end
    end
    // any state change or tick leaves step_n at its default of zero
    always_comb begin
        state_n = state;
        duty_n  = duty;
        step_n  = '0;
        if (!enable) begin
            state_n = led_in ? ON : OFF;
            duty_n  = led_in ? MAX : '0;
        end else begin
            case (state)
                OFF: state_n = led_in ? UP : OFF;
                ON:  state_n = led_in ? ON : DOWN;
                UP: begin
                    if (!led_in) state_n = DOWN;
                    else if (tick) begin
                        duty_n  = duty == MAX ? MAX : duty + 1'b1;
                        state_n = duty >= MAX - ONE ? ON : UP;
                    end else step_n = step_cnt + 1'b1;
                end
                DOWN: begin
                    if (led_in) state_n = UP;
                    else if (tick) begin
                        duty_n  = duty == '0 ? '0 : duty - 1'b1;
                        state_n = duty <= ONE ? OFF : DOWN;
                    end else step_n = step_cnt + 1'b1;
                end
                default: state_n = OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: randomized led_in/enable/reset stimulus checked against a ramp-and-PWM reference model.
module tb_led_fader;
    localparam int PB = 4;
    localparam int SC = 3;
    localparam int MAXV = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_in = 1'b0;
    logic enable = 1'b1;
    logic led_out, busy;
    logic [PB-1:0] duty;
    int n_checks = 0;
    int n_fail = 0;
    int m_duty, m_dir, m_timer, m_pos, m_cmp, m_led;

    led_fader #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .enable(enable),
        .led_out(led_out), .duty(duty), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_duty = 0; m_dir = 0; m_timer = 0; m_pos = 0; m_cmp = 0; m_led = 0;
    endtask

    // brightness moves one LSB toward the led_in level every SC clocks of a ramp
    task automatic model_step();
        int want;
        m_led = enable ? int'(m_pos < m_cmp || m_cmp == MAXV) : int'(led_in);
        if (m_pos == MAXV) m_cmp = m_duty;
        m_pos = (m_pos + 1) % (MAXV + 1);
        want = led_in ? 1 : -1;
        if (!enable) begin
            m_duty = led_in ? MAXV : 0; m_dir = 0; m_timer = 0;
        end else if (m_dir == 0) begin
            if ((want == 1 && m_duty == 0) || (want == -1 && m_duty == MAXV)) begin
                m_dir = want; m_timer = 0;
            end
        end else if (m_dir != want) begin
            m_dir = want; m_timer = 0;
        end else begin
            m_timer++;
            if (m_timer == SC) begin
                m_timer = 0;
                m_duty = m_duty + m_dir;
                if (m_duty < 0) m_duty = 0;
                if (m_duty > MAXV) m_duty = MAXV;
                if ((m_dir == 1 && m_duty == MAXV) || (m_dir == -1 && m_duty == 0)) m_dir = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("duty", int'(duty), m_duty);
        check("busy", int'(busy), int'(m_dir != 0));
        check("led_out", int'(led_out), m_led);
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_led_out", int'(led_out), 0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_duty", int'(duty), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_led_out", int'(led_out), 0);
        rst = 1'b0;
        led_in = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            cycle();
            if (i == 1) check("ramp_busy_on", int'(busy), 1);
            if (i == 4) check("ramp_first_step", int'(duty), 1);
            if (i == 45) check("ramp_pre_top", int'(duty), 14);
            if (i == 46) begin
                check("ramp_top_duty", int'(duty), 15);
                check("ramp_top_busy", int'(busy), 0);
            end
        end
        for (int i = 0; i < 40; i++) cycle();
        led_in = 1'b0;
        for (int i = 0; i < 60 && duty != 4'd6; i++) cycle();
        check("reach_duty6", int'(duty), 6);
        led_in = 1'b1;
        mid_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (i == 1) check("post_rst_busy", int'(busy), 1);
            if (i == 4) check("post_rst_step", int'(duty), 1);
        end
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 39) == 0) led_in = ~led_in;
            if (!enable) begin
                if ($urandom_range(0, 7) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 199) == 0) enable = 1'b0;
            if ($urandom_range(0, 699) == 0) mid_reset();
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
